cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 154 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase instruction sequencer for a small accumulator CPU.
// One instruction takes eight phases: fetch the instruction byte into the IR,
// then decode it into the control strobes for the operand access.
// A HLT instruction parks the sequencer in phase 4 until run is pulsed.
//
// Ports
//   clk           positive-edge clock
//   rst_          asynchronous active-low reset
//   mem_data[7:0] instruction byte from memory: [7:5] opcode, [4:0] address
//   zero          accumulator-is-zero flag, used by SKZ in phase 6
//   run           resume request, only looked at while halted
//   phase[2:0]    current sequencer phase
//   opcode[2:0]   IR[7:5]
//   operand_addr  IR[4:0], load data for the program counter
//   sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt
//                 active-high control strobes
//
// state      | meaning
// INST_ADDR  | put PC on the address bus
// INST_FETCH | read instruction byte
// INST_LOAD  | IR captures mem_data at the end of this phase
// IDLE       | settle
// OP_ADDR    | bump PC; parking phase while halted
// OP_FETCH   | operand read for ALU ops
// ALU_OP     | ALU / jump / store / skip decision
// STORE      | write back or complete, then wrap to INST_ADDR
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst_,
  input  logic [7:0] mem_data,
  input  logic       zero,
  input  logic       run,
  output logic [2:0] phase,
  output logic [2:0] opcode,
  output logic [4:0] operand_addr,
  output logic       sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       load_ir,
  output logic       load_ac,
  output logic       load_pc,
  output logic       inc_pc,
  output logic       data_e,
  output logic       halt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t     state, state_nxt;
  logic       halted, halted_nxt;
  logic [7:0] ir;
  logic       is_aluop;

  assign phase        = state;
  assign opcode       = ir[7:5];
  assign operand_addr = ir[4:0];
  assign is_aluop     = (opcode == OP_ADD) || (opcode == OP_AND) ||
                        (opcode == OP_XOR) || (opcode == OP_LDA);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
      ir     <= 8'h00;
    end else begin
      state  <= state_nxt;
      halted <= halted_nxt;
      if (state == INST_LOAD) ir <= mem_data;
    end
  end

  always_comb begin
    state_nxt  = phase_t'(state + 3'd1);
    halted_nxt = halted;
    sel        = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    load_ir    = 1'b0;
    load_ac    = 1'b0;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    data_e     = 1'b0;
    halt       = 1'b0;

    case (state)
      INST_ADDR: sel = 1'b1;
      INST_FETCH: begin
        sel    = 1'b1;
        mem_rd = 1'b1;
      end
      INST_LOAD: begin
        sel     = 1'b1;
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      IDLE: begin
        sel     = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        halt   = (opcode == OP_HLT);
        inc_pc = !halted;
        if (halted) begin
          // run is only honoured once the halted flag is already set, so a
          // run held high on the entry cycle cannot skip the halt.
          if (run) begin
            halted_nxt = 1'b0;
            state_nxt  = OP_FETCH;
          end else begin
            state_nxt  = OP_ADDR;
          end
        end else if (opcode == OP_HLT) begin
          halted_nxt = 1'b1;
          state_nxt  = OP_ADDR;
        end
      end
      OP_FETCH: mem_rd = is_aluop;
      ALU_OP: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        load_pc = (opcode == OP_JMP);
        data_e  = (opcode == OP_STO);
        inc_pc  = (opcode == OP_SKZ) && zero;
      end
      STORE: begin
        mem_rd  = is_aluop;
        load_ac = is_aluop;
        load_pc = (opcode == OP_JMP);
        data_e  = (opcode == OP_STO);
        mem_wr  = (opcode == OP_STO);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic       clk;
  logic       rst_;
  logic [7:0] mem_data;
  logic       zero;
  logic       run;
  logic [2:0] phase;
  logic [2:0] opcode;
  logic [4:0] operand_addr;
  logic       sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt;
  logic [8:0] strb;

  int n_tests = 0;
  int n_fail  = 0;

  // {sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt}
  assign strb = {sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt};

  cpu_sequencer dut (
    .clk          (clk),
    .rst_         (rst_),
    .mem_data     (mem_data),
    .zero         (zero),
    .run          (run),
    .phase        (phase),
    .opcode       (opcode),
    .operand_addr (operand_addr),
    .sel          (sel),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .load_ir      (load_ir),
    .load_ac      (load_ac),
    .load_pc      (load_pc),
    .inc_pc       (inc_pc),
    .data_e       (data_e),
    .halt         (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe patterns for phases 0-3 (independent of opcode) and phase 4 (not halted).
  localparam logic [8:0] S_P0 = 9'h100;
  localparam logic [8:0] S_P1 = 9'h180;
  localparam logic [8:0] S_P2 = 9'h1A0;
  localparam logic [8:0] S_P3 = 9'h120;
  localparam logic [8:0] S_P4 = 9'h004;

  // Entered at a negedge with phase 0; leaves at a negedge with phase 0.
  task automatic run_inst(input string name, input logic [7:0] md, input logic z,
                          input logic [2:0] exp_op, input logic [4:0] exp_addr,
                          input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] e;
    mem_data = md;
    zero     = z;
    for (int p = 0; p < 8; p++) begin
      case (p)
        0: e = S_P0;
        1: e = S_P1;
        2: e = S_P2;
        3: e = S_P3;
        4: e = S_P4;
        5: e = e5;
        6: e = e6;
        default: e = e7;
      endcase
      check($sformatf("%s phase@%0d", name, p), 32'(phase), 32'(p));
      check($sformatf("%s strobes@%0d", name, p), 32'(strb), 32'(e));
      if (p == 4) begin
        check($sformatf("%s opcode", name), 32'(opcode), 32'(exp_op));
        check($sformatf("%s operand_addr", name), 32'(operand_addr), 32'(exp_addr));
      end
      @(negedge clk);
    end
    check($sformatf("%s wrap", name), 32'(phase), 32'd0);
  endtask

  initial begin
    rst_     = 1'b0;
    mem_data = 8'h00;
    zero     = 1'b0;
    run      = 1'b0;
    #3;
    check("rst phase", 32'(phase), 32'd0);
    check("rst strobes", 32'(strb), 32'(S_P0));
    check("rst opcode", 32'(opcode), 32'd0);
    check("rst addr", 32'(operand_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst held phase", 32'(phase), 32'd0);
    rst_ = 1'b1;
    check("release phase", 32'(phase), 32'd0);
    check("release strobes", 32'(strb), 32'(S_P0));

    run_inst("LDA", 8'hA5, 1'b0, 3'd5, 5'h05, 9'h080, 9'h090, 9'h090);
    run_inst("JMP", 8'hF3, 1'b0, 3'd7, 5'h13, 9'h000, 9'h008, 9'h008);
    run_inst("SKZ1", 8'h20, 1'b1, 3'd1, 5'h00, 9'h000, 9'h004, 9'h000);
    run = 1'b1;   // run must be ignored while not halted
    run_inst("SKZ0", 8'h20, 1'b0, 3'd1, 5'h00, 9'h000, 9'h000, 9'h000);
    run = 1'b0;
    run_inst("STO", 8'hC7, 1'b0, 3'd6, 5'h07, 9'h000, 9'h002, 9'h042);
    run_inst("ADD", 8'h4A, 1'b1, 3'd2, 5'h0A, 9'h080, 9'h090, 9'h090);

    // HLT: park in phase 4, run on the entry cycle ignored.
    mem_data = 8'h00;
    for (int p = 0; p < 4; p++) @(negedge clk);
    check("HLT entry phase", 32'(phase), 32'd4);
    check("HLT entry strobes", 32'(strb), 32'h005);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("HLT hold phase %0d", i), 32'(phase), 32'd4);
      check($sformatf("HLT hold strobes %0d", i), 32'(strb), 32'h001);
      @(negedge clk);
    end
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("HLT resume phase", 32'(phase), 32'd5);
    check("HLT resume strobes", 32'(strb), 32'h000);
    @(negedge clk);
    check("HLT p6 strobes", 32'(strb), 32'h000);
    @(negedge clk);
    check("HLT p7 strobes", 32'(strb), 32'h000);
    @(negedge clk);
    check("HLT refetch phase", 32'(phase), 32'd0);
    check("HLT refetch strobes", 32'(strb), 32'(S_P0));

    // Reset in phase 5 of an LDA.
    mem_data = 8'hA5;
    for (int p = 0; p < 5; p++) @(negedge clk);
    check("midrst pre phase", 32'(phase), 32'd5);
    check("midrst pre strobes", 32'(strb), 32'h080);
    rst_ = 1'b0;
    #1;
    check("midrst phase", 32'(phase), 32'd0);
    check("midrst strobes", 32'(strb), 32'(S_P0));
    check("midrst opcode", 32'(opcode), 32'd0);
    check("midrst addr", 32'(operand_addr), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    check("midrst release phase", 32'(phase), 32'd0);
    @(negedge clk);
    check("midrst first edge", 32'(phase), 32'd1);
    for (int p = 0; p < 7; p++) @(negedge clk);
    check("midrst wrap", 32'(phase), 32'd0);

    // Reset while halted.
    mem_data = 8'h00;
    for (int p = 0; p < 5; p++) @(negedge clk);
    check("haltrst pre strobes", 32'(strb), 32'h001);
    rst_ = 1'b0;
    #1;
    check("haltrst phase", 32'(phase), 32'd0);
    check("haltrst strobes", 32'(strb), 32'(S_P0));
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    check("haltrst first edge", 32'(phase), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
